decode_stage_p: RTL and testbench
=================================

# decode_stage_p

Parametrised decode stage for the five-stage pipeline, sitting between the IF/ID register and execute. It classifies the instruction in `dr`, reads two operands from an internal register file written by the writeback stage, and extends the immediate. It stalls on load-use hazards and registers everything into an ID/EX output register with a valid/ready handshake and flush.

## Interface
- `XLEN`, 32: datapath width; only 32 or 64 are legal.
- `NREGS`, 32: register count, a power of two ≤ 32. `AW` = log2(`NREGS`).
- `BYPASS_WB`, 1: if 1, a same-cycle writeback is forwarded into the operand read.

Ports:
- `clk`  in  1  clock; every register is updated on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `dr` holds an instruction.
- `in_ready`  out  1  stage accepts `dr` this cycle.
- `dr`  in  32  instruction word.
- `wb_en`  in  1  register write enable.
- `wb_addr`  in  5  write address; bits above `AW` are ignored.
- `wb_data`  in  XLEN  write data.
- `flush`  in  1  kill the held instruction and the incoming one.
- `out_valid`  out  1  ID/EX register holds an instruction.
- `out_ready`  in  1  execute consumes the ID/EX register.
- `out_class`  out  3  0 ALU_REG, 1 ALU_INM, 2 LOAD_STORE, 3 BRANCH, 4 JUMP_ABS, 5 JUMP_REL, 6 SHIFT, 7 SHIFT_VAR.
- `out_illegal`  out  1  opcode/funct not decoded.
- `out_a`, `out_b`  out  XLEN  rs and rt operand data.
- `out_ext`  out  XLEN  extended immediate.
- `out_dest`  out  5  destination register; 0 means no write.
- `out_mem_read`  out  1  the instruction is a load.
- `hazard_stall`  out  1  load-use stall is active this cycle.

## Operation
- Instruction fields: op = `dr[31:26]`, rs = `dr[25:21]`, rt = `dr[20:16]`, rd = `dr[15:11]`, funct = `dr[5:0]`, imm = `dr[15:0]`.
- Classification when op = 0:
  - funct 0, 2, 3 → SHIFT.
  - funct 4, 6, 7 → SHIFT_VAR.
  - funct 8, 9 → JUMP_REL.
  - funct 0x20–0x2B → ALU_REG.
  - any other funct → ALU_REG with illegal set.
- Classification for other opcodes:
  - op 1, 4–7 → BRANCH.
  - op 2, 3 → JUMP_ABS.
  - op 8–15 → ALU_INM.
  - op 0x20–0x2B → LOAD_STORE.
  - anything else → class 0 with illegal set.
- Extension:
  - op 12, 13, 14 → zero-extend imm.
  - op 15 → imm << 16, sign-extended from bit 31 to XLEN.
  - JUMP_ABS → zero-extend `dr[25:0]`.
  - everything else → sign-extend imm.
- Destination:
  - ALU_REG, SHIFT, SHIFT_VAR, funct 9 → rd.
  - ALU_INM and op 0x20–0x25 (loads) → rt.
  - op 3 → 31.
  - all others → 0.
  - An illegal instruction always gets dest 0.
- `out_mem_read` = 1 for op 0x20–0x25.
- Register file:
  - `NREGS` × XLEN entries, written on `clk` when `wb_en` is high and `wb_addr` ≠ 0.
  - Register 0 always reads 0.
  - Reads are combinational from `dr` and captured into `out_a`/`out_b`.
  - If `BYPASS_WB` = 1 and a write targets the address being read, `wb_data` is used.
  - If `BYPASS_WB` = 0, the old value is read.
- Load-use hazard:
  - Condition: `out_valid` & `out_mem_read` & `out_dest` ≠ 0 & (`out_dest` = rs or `out_dest` = rt), with `in_valid` high.
  - `hazard_stall` = that condition.
- Handshake:
  - `in_ready` = (!`out_valid` | `out_ready`) & !`hazard_stall`.
  - Accept when `in_valid` & `in_ready`: the ID/EX register loads the decoded instruction and `out_valid` = 1.
  - When `out_ready` is high and nothing is accepted, `out_valid` → 0; this inserts the bubble during a stall.
  - When `out_valid` is high and `out_ready` is low, every `out_*` holds stable.
- Flush has priority over everything: on the next edge `out_valid` = 0, and `in_ready` is forced to 0 during the flush cycle. Register-file writes still occur during a flush.

## Timing
- Reset (async assert, sync release):
  - `out_valid` = 0, `out_class` = 0, `out_illegal` = 0.
  - `out_a` = `out_b` = `out_ext` = 0, `out_dest` = 0, `out_mem_read` = 0.
  - All register-file entries = 0.
  - `in_ready` = 1 after reset, since `out_valid` = 0.
- Latency: one cycle from accept to `out_valid`; full throughput of one instruction per cycle when `out_ready` = 1.
- `in_ready` and `hazard_stall` are combinational from `dr`, `in_valid`, `flush` and registered state. They do not depend on `wb_*`.
- Reset asserted mid-stall clears the ID/EX register immediately; the pending instruction is dropped.
- Simultaneous writeback to rs and accept: the result is governed by `BYPASS_WB`, as above.

## Test plan
- Reset, then accept `addi $2,$1,-5` (0x2022FFFB) with r1 = 7 → one cycle later: `out_class` = 1, `out_ext` = 0xFFFFFFFB, `out_a` = 7, `out_dest` = 2.
- `lw $3,0($4)` followed by `add $5,$3,$6` → `hazard_stall` = 1 for exactly one cycle, one bubble (`out_valid` = 0), then `add` issues with `out_dest` = 5.
- Writeback r9 = 0xDEADBEEF in the same cycle `dr` reads r9 → `out_a` = 0xDEADBEEF with `BYPASS_WB` = 1, and 0 with `BYPASS_WB` = 0.
- `ori $1,$0,0x8000` → `out_ext` = 0x00008000; `lui $1,0x8000` with `XLEN` = 64 → `out_ext` = 0xFFFFFFFF80000000.
- Hold `out_ready` = 0 for 3 cycles with a valid output → outputs stable and `in_ready` = 0; assert `flush` → next cycle `out_valid` = 0.
- Write to r0 (`wb_addr` = 0, data 0x1234) then read r0 → `out_a` = 0; op 0x3F → `out_illegal` = 1, `out_dest` = 0.

Source files
------------

// File: rtl/decode_stage_p.sv
// ID stage: decodes dr, reads the register file, extends the immediate; one-cycle latency into the ID/EX register.
// Holds ID/EX while out_ready is low, stalls in_ready on load-use hazards, flush empties ID/EX.
module decode_stage_p #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int BYPASS_WB = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     dr,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_class,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_ext,
  output logic [4:0]      out_dest,
  output logic            out_mem_read,
  output logic            hazard_stall
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [2:0] CL_ALU_REG   = 3'd0;
  localparam logic [2:0] CL_ALU_INM   = 3'd1;
  localparam logic [2:0] CL_LS        = 3'd2;
  localparam logic [2:0] CL_BRANCH    = 3'd3;
  localparam logic [2:0] CL_JUMP_ABS  = 3'd4;
  localparam logic [2:0] CL_JUMP_REL  = 3'd5;
  localparam logic [2:0] CL_SHIFT     = 3'd6;
  localparam logic [2:0] CL_SHIFT_VAR = 3'd7;

  typedef struct packed {
    logic [2:0]      cls;
    logic            illegal;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] ext;
    logic [4:0]      dest;
    logic            mem_read;
  } idex_t;

  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd;
  logic [15:0]     imm;
  logic [AW-1:0]   rs_i, rt_i, wb_i;
  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] rd_a, rd_b;
  idex_t           dec, idex;
  logic            accept;

  assign op    = dr[31:26];
  assign rs    = dr[25:21];
  assign rt    = dr[20:16];
  assign rd    = dr[15:11];
  assign funct = dr[5:0];
  assign imm   = dr[15:0];
  assign rs_i  = rs[AW-1:0];
  assign rt_i  = rt[AW-1:0];
  assign wb_i  = wb_addr[AW-1:0];

  generate
    if (AW < 5) begin : g_wb_hi
      logic unused_wb_hi;
      assign unused_wb_hi = ^wb_addr[4:AW];
    end
  endgenerate

  // A same-cycle write to the read address is forwarded only when bypass is enabled.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (rs_i != '0) rd_a = (BYPASS_WB != 0 && wb_en && wb_i == rs_i) ? wb_data : rf[rs_i];
    if (rt_i != '0) rd_b = (BYPASS_WB != 0 && wb_en && wb_i == rt_i) ? wb_data : rf[rt_i];
  end

  always_comb begin
    dec     = '0;
    dec.a   = rd_a;
    dec.b   = rd_b;
    dec.ext = XLEN'($signed(imm));
    if (op == 6'd0) begin
      case (funct) inside
        6'd0, 6'd2, 6'd3:  begin dec.cls = CL_SHIFT;     dec.dest = rd; end
        6'd4, 6'd6, 6'd7:  begin dec.cls = CL_SHIFT_VAR; dec.dest = rd; end
        6'd8:              dec.cls = CL_JUMP_REL;
        6'd9:              begin dec.cls = CL_JUMP_REL;  dec.dest = rd; end
        [6'h20:6'h2B]:     begin dec.cls = CL_ALU_REG;   dec.dest = rd; end
        default:           begin dec.cls = CL_ALU_REG;   dec.illegal = 1'b1; end
      endcase
    end else begin
      case (op) inside
        6'd1, [6'd4:6'd7]: dec.cls = CL_BRANCH;
        6'd2:              begin dec.cls = CL_JUMP_ABS; dec.ext = XLEN'(dr[25:0]); end
        6'd3:              begin dec.cls = CL_JUMP_ABS; dec.ext = XLEN'(dr[25:0]); dec.dest = 5'd31; end
        [6'd8:6'd15]:      begin dec.cls = CL_ALU_INM;  dec.dest = rt; end
        [6'h20:6'h25]:     begin dec.cls = CL_LS;       dec.dest = rt; dec.mem_read = 1'b1; end
        [6'h26:6'h2B]:     dec.cls = CL_LS;
        default:           dec.illegal = 1'b1;
      endcase
      if (op inside {6'd12, 6'd13, 6'd14}) dec.ext = XLEN'(imm);
      if (op == 6'd15)                     dec.ext = XLEN'($signed({imm, 16'h0000}));
    end
    if (dec.illegal) dec.dest = '0;
  end

  assign hazard_stall = in_valid & out_valid & out_mem_read & (out_dest != 5'd0) &
                        ((out_dest == rs) | (out_dest == rt));
  assign in_ready     = (!out_valid | out_ready) & !hazard_stall & !flush;
  assign accept       = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_en && wb_i != '0) begin
      rf[wb_i] <= wb_data;
    end
  end

  // Flush wins over accept; a drained register with no accept becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      idex      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      idex      <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_class    = idex.cls;
  assign out_illegal  = idex.illegal;
  assign out_a        = idex.a;
  assign out_b        = idex.b;
  assign out_ext      = idex.ext;
  assign out_dest     = idex.dest;
  assign out_mem_read = idex.mem_read;
endmodule

// File: tb/tb_decode_stage_p.sv
// Scoreboard bench for decode_stage_p: default instance plus no-bypass and 64-bit instances on shared inputs.
module tb_decode_stage_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, wb_en, flush, out_ready;
  logic [31:0] dr;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;

  logic        in_ready, out_valid, out_illegal, out_mem_read, hazard_stall;
  logic [2:0]  out_class;
  logic [31:0] out_a, out_b, out_ext;
  logic [4:0]  out_dest;

  logic        nb_in_ready, nb_out_valid, nb_out_illegal, nb_out_mem_read, nb_hazard_stall;
  logic [2:0]  nb_out_class;
  logic [31:0] nb_out_a, nb_out_b, nb_out_ext;
  logic [4:0]  nb_out_dest;

  logic        w_in_ready, w_out_valid, w_out_illegal, w_out_mem_read, w_hazard_stall;
  logic [2:0]  w_out_class;
  logic [63:0] w_out_a, w_out_b, w_out_ext;
  logic [4:0]  w_out_dest;

  decode_stage_p #(.XLEN(32), .NREGS(32), .BYPASS_WB(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .dr(dr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data[31:0]), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_illegal(out_illegal), .out_a(out_a), .out_b(out_b), .out_ext(out_ext),
    .out_dest(out_dest), .out_mem_read(out_mem_read), .hazard_stall(hazard_stall));

  decode_stage_p #(.XLEN(32), .NREGS(32), .BYPASS_WB(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nb_in_ready), .dr(dr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data[31:0]), .flush(flush),
    .out_valid(nb_out_valid), .out_ready(out_ready), .out_class(nb_out_class),
    .out_illegal(nb_out_illegal), .out_a(nb_out_a), .out_b(nb_out_b), .out_ext(nb_out_ext),
    .out_dest(nb_out_dest), .out_mem_read(nb_out_mem_read), .hazard_stall(nb_hazard_stall));

  decode_stage_p #(.XLEN(64), .NREGS(32), .BYPASS_WB(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .dr(dr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_class(w_out_class),
    .out_illegal(w_out_illegal), .out_a(w_out_a), .out_b(w_out_b), .out_ext(w_out_ext),
    .out_dest(w_out_dest), .out_mem_read(w_out_mem_read), .hazard_stall(w_hazard_stall));

  typedef struct packed {
    logic [2:0]  cls;
    logic        ill;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ext;
    logic [4:0]  dest;
    logic        mr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp, mon_act;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_xfer   = 0;

  function automatic exp_t mk(input logic [2:0] cls, input logic ill, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] ext,
                              input logic [4:0] dest, input logic mr);
    exp_t e;
    e.cls = cls; e.ill = ill; e.a = a; e.b = b; e.ext = ext; e.dest = dest; e.mr = mr;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every transfer on the default instance is matched against the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL xfer%0d: output with empty scoreboard, dest=%0d", n_xfer, out_dest);
      end else begin
        mon_exp = sb.pop_front();
        mon_act = mk(out_class, out_illegal, out_a, out_b, out_ext, out_dest, out_mem_read);
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL xfer%0d: got cls=%0d ill=%0b a=%h b=%h ext=%h dest=%0d mr=%0b, expected cls=%0d ill=%0b a=%h b=%h ext=%h dest=%0d mr=%0b",
                   n_xfer, mon_act.cls, mon_act.ill, mon_act.a, mon_act.b, mon_act.ext, mon_act.dest, mon_act.mr,
                   mon_exp.cls, mon_exp.ill, mon_exp.a, mon_exp.b, mon_exp.ext, mon_exp.dest, mon_exp.mr);
        end
      end
      n_xfer++;
    end
  end

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_en = 1'b1; wb_addr = a; wb_data = {32'h0, d};
    @(posedge clk);
    #1 wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input exp_t e);
    int n;
    sb.push_back(e);
    @(negedge clk);
    dr = ins; in_valid = 1'b1;
    n = 0;
    #1;
    while (in_ready !== 1'b1 && n <= 50) begin
      @(negedge clk);
      #1 n++;
    end
    if (n > 50) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      void'(sb.pop_back());
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, got %0d transfers, expected completion", n_xfer);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; dr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_class", 64'(out_class), 64'd0);
    check("rst_out_illegal", 64'(out_illegal), 64'd0);
    check("rst_out_a", 64'(out_a), 64'd0);
    check("rst_out_b", 64'(out_b), 64'd0);
    check("rst_out_ext", 64'(out_ext), 64'd0);
    check("rst_out_dest", 64'(out_dest), 64'd0);
    check("rst_out_mem_read", 64'(out_mem_read), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    wb(5'd1, 32'd7);
    wb(5'd2, 32'h22);
    wb(5'd3, 32'h33);
    wb(5'd4, 32'h44);
    wb(5'd6, 32'h66);
    wb(5'd0, 32'h1234);

    issue(32'h2022FFFB, mk(3'd1, 1'b0, 32'd7, 32'h22, 32'hFFFFFFFB, 5'd2, 1'b0));

    // Load-use: lw $3 then add using $3 stalls once and leaves one bubble.
    issue(32'h8C830000, mk(3'd2, 1'b0, 32'h44, 32'h33, 32'h0, 5'd3, 1'b1));
    @(negedge clk);
    dr = 32'h00662820; in_valid = 1'b1;
    #1;
    check("lu_stall_on", 64'(hazard_stall), 64'd1);
    check("lu_in_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    #1;
    check("lu_stall_off", 64'(hazard_stall), 64'd0);
    check("lu_bubble", 64'(out_valid), 64'd0);
    check("lu_in_ready_back", 64'(in_ready), 64'd1);
    sb.push_back(mk(3'd0, 1'b0, 32'h33, 32'h66, 32'h00002820, 5'd5, 1'b0));
    @(posedge clk);
    #1 in_valid = 1'b0;

    // Same-cycle writeback of r9 while dr reads r9.
    @(negedge clk);
    dr = 32'h01203821; in_valid = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'h00000000DEADBEEF;
    sb.push_back(mk(3'd0, 1'b0, 32'hDEADBEEF, 32'h0, 32'h00003821, 5'd7, 1'b0));
    @(posedge clk);
    #1 in_valid = 1'b0; wb_en = 1'b0;
    @(negedge clk);
    #1;
    check("bypass_a", 64'(out_a), 64'hDEADBEEF);
    check("nobypass_a", 64'(nb_out_a), 64'h0);
    issue(32'h01203821, mk(3'd0, 1'b0, 32'hDEADBEEF, 32'h0, 32'h00003821, 5'd7, 1'b0));
    @(negedge clk);
    #1 check("nobypass_later_a", 64'(nb_out_a), 64'hDEADBEEF);

    issue(32'h34018000, mk(3'd1, 1'b0, 32'h0, 32'd7, 32'h00008000, 5'd1, 1'b0));
    issue(32'h3C018000, mk(3'd1, 1'b0, 32'h0, 32'd7, 32'h80000000, 5'd1, 1'b0));
    @(negedge clk);
    #1 check("lui_ext_xlen64", w_out_ext, 64'hFFFFFFFF80000000);

    // Backpressure: sll held for three cycles, then flushed along with the waiting jalr.
    @(negedge clk);
    out_ready = 1'b0;
    issue(32'h000240C0, mk(3'd6, 1'b0, 32'h0, 32'h22, 32'h000040C0, 5'd8, 1'b0));
    @(negedge clk);
    dr = 32'h0080F809; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_class", 64'(out_class), 64'd6);
      check("hold_b", 64'(out_b), 64'h22);
      check("hold_ext", 64'(out_ext), 64'h40C0);
      check("hold_dest", 64'(out_dest), 64'd8);
      @(negedge clk);
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    check("flush_kills_valid", 64'(out_valid), 64'd0);
    void'(sb.pop_back());
    out_ready = 1'b1;
    @(negedge clk);
    dr = 32'h0080F809; in_valid = 1'b1; flush = 1'b1;
    #1 check("flush_forces_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    #1 check("flush_no_accept", 64'(out_valid), 64'd0);

    issue(32'h08123456, mk(3'd4, 1'b0, 32'h0, 32'h0, 32'h00123456, 5'd0, 1'b0));
    issue(32'h0C000010, mk(3'd4, 1'b0, 32'h0, 32'h0, 32'h00000010, 5'd31, 1'b0));
    issue(32'h1022FFFF, mk(3'd3, 1'b0, 32'd7, 32'h22, 32'hFFFFFFFF, 5'd0, 1'b0));
    issue(32'h0080F809, mk(3'd5, 1'b0, 32'h44, 32'h0, 32'hFFFFF809, 5'd31, 1'b0));
    issue(32'h00015021, mk(3'd0, 1'b0, 32'h0, 32'd7, 32'h00005021, 5'd10, 1'b0));
    issue(32'hFC200000, mk(3'd0, 1'b1, 32'd7, 32'h0, 32'h0, 5'd0, 1'b0));
    issue(32'h0000283F, mk(3'd0, 1'b1, 32'h0, 32'h0, 32'h0000283F, 5'd0, 1'b0));
    issue(32'h00432006, mk(3'd7, 1'b0, 32'h22, 32'h33, 32'h00002006, 5'd4, 1'b0));
    issue(32'hAC830004, mk(3'd2, 1'b0, 32'h44, 32'h33, 32'h00000004, 5'd0, 1'b0));
    issue(32'h3025FFFF, mk(3'd1, 1'b0, 32'd7, 32'h0, 32'h0000FFFF, 5'd5, 1'b0));

    repeat (4) @(negedge clk);
    #3 check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
